// File: rtl/pwr_ctrl_pkg.sv
// Shared types for the power-control AXI-Lite master path.
//   arb_state_t   : arbiter/bridge FSM states
//   owner_t       : which requester owns the in-flight transaction
//   AXI_RESP_OKAY : AXI response code for a successful transfer
package pwr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_MAESTRO,
        OWN_FSM,
        OWN_READ
    } owner_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle (aw/w/b/ar/r channels).
//   Master modport: drives addresses, write data, valids on aw/w/ar and
//                   ready on b/r.
//   Slave modport : the mirror image.
interface AXI_LITE #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport Master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );

    modport Slave (
        input aw_addr, aw_prot, aw_valid, output aw_ready,
        input w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
endinterface

// File: rtl/pwr_axil_master_arb.sv
// AXI-Lite master arbiter/bridge behind the power-control FSM.
// Merges a maestro write, an fsm write and a single-word read onto one
// AXI-Lite master port, one outstanding transaction at a time.
// Fixed priority: maestro write > fsm write > pending read.
// Ports:
//   maestro_adress_i/data_i/req_i, maestro_ack_o : maestro write, level req
//   fsm_adress_i/data_i/req_i, fsm_ack_o         : fsm write, level req
//   adress_i, req_i, ready_o                      : read request (pulse)
//   data_o, valid_o                               : read return (pulse)
//   bus_err_o                                     : sticky non-OKAY response
//   axi_master                                    : AXI-Lite master port
module pwr_axil_master_arb
    import pwr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] maestro_adress_i,
    input  logic [DATA_WIDTH-1:0] maestro_data_i,
    input  logic                  maestro_req_i,
    output logic                  maestro_ack_o,
    input  logic [ADDR_WIDTH-1:0] fsm_adress_i,
    input  logic [DATA_WIDTH-1:0] fsm_data_i,
    input  logic                  fsm_req_i,
    output logic                  fsm_ack_o,
    input  logic [ADDR_WIDTH-1:0] adress_i,
    input  logic                  req_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  bus_err_o,
    AXI_LITE.Master               axi_master
);

    arb_state_t            state_reg, state_next;
    owner_t                owner_reg, owner_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  aw_valid_reg, aw_valid_next;
    logic                  w_valid_reg, w_valid_next;
    logic                  ar_valid_reg, ar_valid_next;
    logic                  rd_pending_reg, rd_pending_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic                  maestro_ack_reg, maestro_ack_next;
    logic                  fsm_ack_reg, fsm_ack_next;
    logic                  valid_reg, valid_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  bus_err_reg, bus_err_next;
    logic                  pulse_guard;

    // A pulse currently on an ack/valid output means the requester has not
    // yet had a chance to drop its request, so hold off arbitration a cycle.
    assign pulse_guard = maestro_ack_reg | fsm_ack_reg | valid_reg;

    assign ready_o = !rd_pending_reg && (state_reg != ST_RD_AR) && (state_reg != ST_RD_R);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            owner_reg       <= OWN_MAESTRO;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            aw_valid_reg    <= 1'b0;
            w_valid_reg     <= 1'b0;
            ar_valid_reg    <= 1'b0;
            rd_pending_reg  <= 1'b0;
            rd_addr_reg     <= '0;
            maestro_ack_reg <= 1'b0;
            fsm_ack_reg     <= 1'b0;
            valid_reg       <= 1'b0;
            rdata_reg       <= '0;
            bus_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            aw_valid_reg    <= aw_valid_next;
            w_valid_reg     <= w_valid_next;
            ar_valid_reg    <= ar_valid_next;
            rd_pending_reg  <= rd_pending_next;
            rd_addr_reg     <= rd_addr_next;
            maestro_ack_reg <= maestro_ack_next;
            fsm_ack_reg     <= fsm_ack_next;
            valid_reg       <= valid_next;
            rdata_reg       <= rdata_next;
            bus_err_reg     <= bus_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        aw_valid_next    = aw_valid_reg;
        w_valid_next     = w_valid_reg;
        ar_valid_next    = ar_valid_reg;
        rd_pending_next  = rd_pending_reg;
        rd_addr_next     = rd_addr_reg;
        maestro_ack_next = 1'b0;
        fsm_ack_next     = 1'b0;
        valid_next       = 1'b0;
        rdata_next       = rdata_reg;
        bus_err_next     = bus_err_reg;

        // Read capture is independent of the FSM so a read can queue up
        // behind an in-flight write.
        if (req_i && ready_o) begin
            rd_pending_next = 1'b1;
            rd_addr_next    = adress_i;
        end

        case (state_reg)
            ST_IDLE: begin
                if (!pulse_guard) begin
                    if (maestro_req_i) begin
                        owner_next    = OWN_MAESTRO;
                        addr_next     = maestro_adress_i;
                        wdata_next    = maestro_data_i;
                        aw_valid_next = 1'b1;
                        w_valid_next  = 1'b1;
                        state_next    = ST_WR_AW_W;
                    end else if (fsm_req_i) begin
                        owner_next    = OWN_FSM;
                        addr_next     = fsm_adress_i;
                        wdata_next    = fsm_data_i;
                        aw_valid_next = 1'b1;
                        w_valid_next  = 1'b1;
                        state_next    = ST_WR_AW_W;
                    end else if (rd_pending_reg) begin
                        owner_next    = OWN_READ;
                        addr_next     = rd_addr_reg;
                        ar_valid_next = 1'b1;
                        state_next    = ST_RD_AR;
                    end
                end
            end
            ST_WR_AW_W: begin
                // AW and W complete independently, in any order.
                if (axi_master.aw_ready) begin
                    aw_valid_next = 1'b0;
                end
                if (axi_master.w_ready) begin
                    w_valid_next = 1'b0;
                end
                if (!aw_valid_next && !w_valid_next) begin
                    state_next = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (axi_master.b_valid) begin
                    if (owner_reg == OWN_MAESTRO) begin
                        maestro_ack_next = 1'b1;
                    end else begin
                        fsm_ack_next = 1'b1;
                    end
                    if (axi_master.b_resp != AXI_RESP_OKAY) begin
                        bus_err_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
            end
            ST_RD_AR: begin
                if (axi_master.ar_ready) begin
                    ar_valid_next = 1'b0;
                    state_next    = ST_RD_R;
                end
            end
            ST_RD_R: begin
                if (axi_master.r_valid) begin
                    rdata_next      = axi_master.r_data;
                    valid_next      = 1'b1;
                    rd_pending_next = 1'b0;
                    if (axi_master.r_resp != AXI_RESP_OKAY) begin
                        bus_err_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign maestro_ack_o = maestro_ack_reg;
    assign fsm_ack_o     = fsm_ack_reg;
    assign valid_o       = valid_reg;
    assign data_o        = rdata_reg;
    assign bus_err_o     = bus_err_reg;

    assign axi_master.aw_addr  = addr_reg;
    assign axi_master.aw_prot  = 3'b000;
    assign axi_master.aw_valid = aw_valid_reg;
    assign axi_master.w_data   = wdata_reg;
    assign axi_master.w_strb   = '1;
    assign axi_master.w_valid  = w_valid_reg;
    assign axi_master.b_ready  = (state_reg == ST_WR_B);
    assign axi_master.ar_addr  = addr_reg;
    assign axi_master.ar_prot  = 3'b000;
    assign axi_master.ar_valid = ar_valid_reg;
    assign axi_master.r_ready  = (state_reg == ST_RD_R);

endmodule

// File: tb/tb_pwr_axil_master_arb.sv
// Directed bench for pwr_axil_master_arb with a configurable AXI-Lite slave.
// Inputs and slave readies are driven on the falling edge; DUT outputs are
// checked on the falling edge.
module tb_pwr_axil_master_arb;

    logic        clk;
    logic        rst_n;
    logic [31:0] maestro_adress;
    logic [31:0] maestro_data;
    logic        maestro_req;
    logic        maestro_ack;
    logic [31:0] fsm_adress;
    logic [31:0] fsm_data;
    logic        fsm_req;
    logic        fsm_ack;
    logic [31:0] adress;
    logic        req;
    logic        ready;
    logic [31:0] data;
    logic        valid;
    logic        bus_err;

    AXI_LITE #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    pwr_axil_master_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .maestro_adress_i (maestro_adress),
        .maestro_data_i   (maestro_data),
        .maestro_req_i    (maestro_req),
        .maestro_ack_o    (maestro_ack),
        .fsm_adress_i     (fsm_adress),
        .fsm_data_i       (fsm_data),
        .fsm_req_i        (fsm_req),
        .fsm_ack_o        (fsm_ack),
        .adress_i         (adress),
        .req_i            (req),
        .ready_o          (ready),
        .data_o           (data),
        .valid_o          (valid),
        .bus_err_o        (bus_err),
        .axi_master       (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // slave configuration and bookkeeping
    int          aw_delay   = 0;
    int          w_delay    = 0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic        b_stall    = 1'b0;
    logic [31:0] r_data_cfg = 32'hDEAD_BEEF;
    int          aw_hs = 0;
    int          b_hs  = 0;
    int          ar_hs = 0;
    int          aw_wait = 0;
    int          w_wait  = 0;
    logic        aw_done = 1'b0;
    logic        w_done  = 1'b0;
    logic        ar_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // AXI-Lite slave: handshakes are sampled at the rising edge, readies and
    // responses are driven at the falling edge.
    initial begin
        axi.aw_ready = 1'b0;
        axi.w_ready  = 1'b0;
        axi.b_valid  = 1'b0;
        axi.b_resp   = 2'b00;
        axi.ar_ready = 1'b0;
        axi.r_valid  = 1'b0;
        axi.r_data   = '0;
        axi.r_resp   = 2'b00;
        forever begin
            @(posedge clk);
            if (axi.aw_valid && axi.aw_ready) begin
                aw_done = 1'b1; aw_hs++; aw_wait = 0;
            end
            if (axi.w_valid && axi.w_ready) begin
                w_done = 1'b1; w_wait = 0;
            end
            if (axi.b_valid && axi.b_ready) begin
                aw_done = 1'b0; w_done = 1'b0; b_hs++;
            end
            if (axi.ar_valid && axi.ar_ready) begin
                ar_done = 1'b1; ar_hs++;
            end
            if (axi.r_valid && axi.r_ready) begin
                ar_done = 1'b0;
            end
            @(negedge clk);
            if (!rst_n) begin
                aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
                aw_wait = 0; w_wait = 0;
                axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0;
                axi.ar_ready = 1'b0; axi.r_valid = 1'b0;
            end else begin
                axi.aw_ready = axi.aw_valid && !aw_done && (aw_wait >= aw_delay);
                if (axi.aw_valid && !aw_done) aw_wait++;
                axi.w_ready = axi.w_valid && !w_done && (w_wait >= w_delay);
                if (axi.w_valid && !w_done) w_wait++;
                axi.b_valid  = aw_done && w_done && !b_stall;
                axi.b_resp   = b_resp_cfg;
                axi.ar_ready = axi.ar_valid && !ar_done;
                axi.r_valid  = ar_done;
                axi.r_data   = r_data_cfg;
                axi.r_resp   = 2'b00;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        maestro_adress = '0; maestro_data = '0; maestro_req = 1'b0;
        fsm_adress = '0; fsm_data = '0; fsm_req = 1'b0;
        adress = '0; req = 1'b0;

        // reset state
        step(2);
        chk("rst maestro_ack", 32'(maestro_ack), 0);
        chk("rst fsm_ack", 32'(fsm_ack), 0);
        chk("rst valid_o", 32'(valid), 0);
        chk("rst bus_err", 32'(bus_err), 0);
        chk("rst data_o", data, 0);
        chk("rst aw_valid", 32'(axi.aw_valid), 0);
        chk("rst ar_valid", 32'(axi.ar_valid), 0);
        chk("rst b_ready", 32'(axi.b_ready), 0);
        chk("rst ready_o", 32'(ready), 1);
        $display("reset: ready_o=%0b", ready);
        rst_n = 1'b1;
        step(2);

        // single maestro write, zero-wait slave
        maestro_adress = 32'h0000_0054; maestro_data = 32'h2; maestro_req = 1'b1;
        step(1);
        chk("m1 aw_valid", 32'(axi.aw_valid), 1);
        chk("m1 w_valid", 32'(axi.w_valid), 1);
        chk("m1 aw_addr", axi.aw_addr, 32'h54);
        chk("m1 w_data", axi.w_data, 32'h2);
        chk("m1 w_strb", 32'(axi.w_strb), 32'hF);
        chk("m1 aw_prot", 32'(axi.aw_prot), 0);
        step(1);
        chk("m1 aw_valid drop", 32'(axi.aw_valid), 0);
        chk("m1 b_ready", 32'(axi.b_ready), 1);
        step(1);
        chk("m1 ack", 32'(maestro_ack), 1);
        chk("m1 fsm_ack", 32'(fsm_ack), 0);
        maestro_req = 1'b0;
        step(1);
        chk("m1 ack one pulse", 32'(maestro_ack), 0);
        step(3);
        chk("m1 no reissue", 32'(axi.aw_valid), 0);
        chk("m1 aw count", aw_hs, 1);
        $display("write maestro addr=0x54 data=0x2 aw_hs=%0d", aw_hs);

        // maestro and fsm simultaneous
        maestro_adress = 32'h100; maestro_data = 32'hA; maestro_req = 1'b1;
        fsm_adress = 32'h200; fsm_data = 32'hB; fsm_req = 1'b1;
        step(1);
        chk("pri first aw_addr", axi.aw_addr, 32'h100);
        chk("pri first w_data", axi.w_data, 32'hA);
        step(2);
        chk("pri maestro_ack", 32'(maestro_ack), 1);
        chk("pri fsm_ack early", 32'(fsm_ack), 0);
        maestro_req = 1'b0;
        step(2);
        chk("pri second aw_valid", 32'(axi.aw_valid), 1);
        chk("pri second aw_addr", axi.aw_addr, 32'h200);
        chk("pri second w_data", axi.w_data, 32'hB);
        step(2);
        chk("pri fsm_ack", 32'(fsm_ack), 1);
        chk("pri maestro_ack late", 32'(maestro_ack), 0);
        fsm_req = 1'b0;
        step(2);
        chk("pri aw count", aw_hs, 3);
        $display("write maestro+fsm aw_hs=%0d", aw_hs);

        // read captured during an fsm write
        fsm_adress = 32'h300; fsm_data = 32'hC; fsm_req = 1'b1;
        step(1);
        chk("rd ready before", 32'(ready), 1);
        adress = 32'h3; req = 1'b1;
        step(1);
        req = 1'b0;
        chk("rd ready after capture", 32'(ready), 0);
        chk("rd b_ready", 32'(axi.b_ready), 1);
        step(1);
        chk("rd fsm_ack", 32'(fsm_ack), 1);
        chk("rd no ar yet", 32'(axi.ar_valid), 0);
        fsm_req = 1'b0;
        step(1);
        chk("rd guard cycle", 32'(axi.ar_valid), 0);
        step(1);
        chk("rd ar_valid", 32'(axi.ar_valid), 1);
        chk("rd ar_addr", axi.ar_addr, 32'h3);
        chk("rd ar_prot", 32'(axi.ar_prot), 0);
        step(1);
        chk("rd r_ready", 32'(axi.r_ready), 1);
        chk("rd ar drop", 32'(axi.ar_valid), 0);
        chk("rd valid early", 32'(valid), 0);
        step(1);
        chk("rd valid_o", 32'(valid), 1);
        chk("rd data_o", data, 32'hDEAD_BEEF);
        chk("rd ready again", 32'(ready), 1);
        step(1);
        chk("rd valid one pulse", 32'(valid), 0);
        chk("rd ar count", ar_hs, 1);
        $display("read addr=0x3 data=0x%0h", data);

        // w_ready three cycles before aw_ready
        aw_delay = 3;
        maestro_adress = 32'h54; maestro_data = 32'h5; maestro_req = 1'b1;
        step(1);
        chk("ord aw_valid", 32'(axi.aw_valid), 1);
        chk("ord w_valid", 32'(axi.w_valid), 1);
        step(1);
        chk("ord w drops first", 32'(axi.w_valid), 0);
        chk("ord aw held", 32'(axi.aw_valid), 1);
        step(1);
        chk("ord aw held 2", 32'(axi.aw_valid), 1);
        chk("ord aw_addr stable", axi.aw_addr, 32'h54);
        chk("ord no b_ready", 32'(axi.b_ready), 0);
        step(2);
        chk("ord aw done", 32'(axi.aw_valid), 0);
        chk("ord b_ready", 32'(axi.b_ready), 1);
        step(1);
        chk("ord ack", 32'(maestro_ack), 1);
        maestro_req = 1'b0;
        aw_delay = 0;
        step(2);
        chk("ord b count", b_hs, 5);
        $display("write w-before-aw b_hs=%0d", b_hs);

        // error response
        b_resp_cfg = 2'b10;
        fsm_adress = 32'h400; fsm_data = 32'hD; fsm_req = 1'b1;
        step(3);
        chk("err ack", 32'(fsm_ack), 1);
        chk("err bus_err", 32'(bus_err), 1);
        fsm_req = 1'b0;
        b_resp_cfg = 2'b00;
        step(3);
        chk("err sticky", 32'(bus_err), 1);
        $display("write fsm slverr bus_err=%0b", bus_err);

        // reset while waiting in WR_B
        b_stall = 1'b1;
        maestro_adress = 32'h500; maestro_data = 32'hE; maestro_req = 1'b1;
        step(2);
        chk("arst in WR_B", 32'(axi.b_ready), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst b_ready", 32'(axi.b_ready), 0);
        chk("arst aw_valid", 32'(axi.aw_valid), 0);
        chk("arst w_valid", 32'(axi.w_valid), 0);
        chk("arst bus_err", 32'(bus_err), 0);
        chk("arst data_o", data, 0);
        chk("arst maestro_ack", 32'(maestro_ack), 0);
        maestro_req = 1'b0;
        step(2);
        rst_n = 1'b1;
        b_stall = 1'b0;
        step(2);
        chk("post ready_o", 32'(ready), 1);
        chk("post aw_valid", 32'(axi.aw_valid), 0);
        chk("post ar_valid", 32'(axi.ar_valid), 0);
        chk("post b_ready", 32'(axi.b_ready), 0);
        $display("reset mid-write ready_o=%0b bus_err=%0b", ready, bus_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwr_axil_master_arb.md
Name: pwr_axil_master_arb

Overview:
- AXI-Lite master arbiter and bridge sitting directly downstream of the power-control FSM.
- Merges three requesters onto one AXI-Lite master port, one outstanding transaction at a time:
  - maestro write (power-domain transitions to SYSCFG);
  - observation-forward write (fsm);
  - single-word read (fetch/compute).
- Returns per-requester ack, read data and a sticky bus-error flag.

Parameters:
ADDR_WIDTH, 32, AXI-Lite address width
DATA_WIDTH, 32, AXI-Lite data width (w_strb width = DATA_WIDTH/8)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
maestro_adress_i  in  ADDR_WIDTH  maestro write address
maestro_data_i  in  DATA_WIDTH  maestro write data
maestro_req_i  in  1  maestro write request, level, held until ack
maestro_ack_o  out  1  one-cycle pulse: maestro write completed (B received)
fsm_adress_i  in  ADDR_WIDTH  fsm write address
fsm_data_i  in  DATA_WIDTH  fsm write data
fsm_req_i  in  1  fsm write request, level, held until ack
fsm_ack_o  out  1  one-cycle pulse: fsm write completed
adress_i  in  ADDR_WIDTH  read address
req_i  in  1  read request, single-cycle pulse, accepted only when ready_o=1
ready_o  out  1  read channel can accept a request
data_o  out  DATA_WIDTH  read data, valid while valid_o=1
valid_o  out  1  one-cycle pulse: read data returned
bus_err_o  out  1  sticky: any B/R response != OKAY; cleared only by reset
axi_master  AXI_LITE.Master  -  aw/w/b/ar/r channels; aw_prot=ar_prot=0, w_strb all ones

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, rd_pending=0;
  - all acks/valid_o/bus_err_o = 0, data_o = 0;
  - all AXI valid/ready outputs = 0.
- Read capture:
  - ready_o = !rd_pending && state not in read phases.
  - req_i && ready_o latches adress_i and sets rd_pending the next cycle.
  - req_i while ready_o=0 is ignored; this is the requester's fault.
- Arbitration happens in IDLE only, when no ack/valid pulse was issued in the previous cycle (one-cycle guard so a requester can drop req after ack).
- Fixed priority: maestro_req_i > fsm_req_i > rd_pending.
- Address and data are latched at grant.
- States:
  - IDLE: grant as above, then go to WR_AW_W (maestro/fsm) or RD_AR (read).
  - WR_AW_W:
    - aw_valid and w_valid are asserted in the cycle after grant.
    - Each drops independently on its own handshake (aw_ready / w_ready in either order or simultaneously).
    - When both are done, go to WR_B.
  - WR_B:
    - b_ready=1.
    - On b_valid: pulse the owner's ack the next cycle, set bus_err_o if b_resp!=0, return to IDLE.
  - RD_AR: ar_valid=1 until ar_ready, then go to RD_R.
  - RD_R:
    - r_ready=1.
    - On r_valid: register r_data to data_o, pulse valid_o, clear rd_pending, set bus_err_o if r_resp!=0, return to IDLE.
- Latency with a zero-wait slave: write grant to ack is 3 cycles; read accept to valid_o is 4 cycles.
- Valid signals are never dropped before their handshake (AXI rule).
- Address and data are stable while valid is high.
- Simultaneous events:
  - maestro and fsm requests both high: maestro goes first and fsm waits.
  - Read pulse arriving while a write is granted: captured if ready_o=1 and served after the write.
- A requester dropping req before ack is not supported; the transaction completes and the ack is still pulsed.
- Reset mid-transaction: FSM returns to IDLE immediately and all valids drop. The slave must also be reset.
- No timeout: the arbiter waits indefinitely on a stalled slave.

Decomposition:
- Shared package pwr_ctrl_pkg:
  - arbiter state enum arb_state_t;
  - owner enum {OWN_MAESTRO, OWN_FSM, OWN_READ};
  - AXI_RESP_OKAY constant.
- No sub-module; the single FSM plus the read-pending latch fit in one file.

Test Plan:
- maestro_req_i=1 at 0x0000_0054, data 0x2, zero-wait slave -> aw/w valid together in cycle+1 carrying 0x54 / 0x2; maestro_ack_o pulses once; no re-issue after req drops.
- maestro and fsm requests in the same cycle -> maestro write goes on the bus first, then fsm; acks in that order; exactly 2 AW handshakes.
- Read pulse at 0x3 during an in-flight fsm write -> ready_o drops, AR 0x3 issued after B; slave returns 0xDEADBEEF -> data_o=0xDEADBEEF with valid_o for exactly 1 cycle.
- Slave asserts w_ready 3 cycles before aw_ready -> w_valid drops first, aw_valid held; a single B completes the write.
- Slave returns b_resp=2'b10 -> ack still pulses, bus_err_o=1 and stays 1 until rst_n.
- rst_n asserted while in WR_B -> all outputs return to reset values asynchronously; after release, IDLE and ready_o=1.
